cfg_cmd_master: RTL and testbench

Bus initiator for the internal configuration register interface. It parses fixed-length command frames from an upstream byte stream (UDP/UART receive path) and issues single-cycle `inter_cfg_wr_en`/`inter_cfg_rd_en` accesses. It collects `inter_cfg_rd_data_valid` from the register file and serialises an acknowledge or read-response frame back to the byte transmit path. It sits between the link-layer byte interfaces and the configuration register file.

---
 rtl/cfg_cmd_pkg.sv | 37 +++
 rtl/cfg_cmd_master_if.sv | 35 +++
 rtl/cfg_resp_ser.sv | 76 +++++++
 rtl/cfg_cmd_master.sv | 204 ++++++++++++++++++++
 tb/tb_cfg_cmd_master.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_cmd_pkg.sv
// Shared constants, state encoding and checksum helper for the configuration
// command master and its response serialiser.
package cfg_cmd_pkg;

  localparam logic [7:0] HDR0       = 8'hEB;
  localparam logic [7:0] HDR1       = 8'h90;

  localparam logic [7:0] CMD_WR     = 8'h01;
  localparam logic [7:0] CMD_RD     = 8'h02;
  localparam logic [7:0] CMD_WR_ACK = 8'h81;
  localparam logic [7:0] CMD_RD_RSP = 8'h82;
  localparam logic [7:0] CMD_RD_TMO = 8'h83;

  // Header (2) + CMD (1) + ADDR (2) + DATA (4) + CHK (1)
  localparam int unsigned FRAME_LEN = 10;
  // Bytes following the header: CMD through CHK
  localparam int unsigned BODY_LEN  = 8;

  typedef enum logic [2:0] {
    ST_HUNT0,
    ST_HUNT1,
    ST_BODY,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_RESP
  } state_t;

  // 8-bit wrapping sum of CMD, ADDR and DATA bytes
  function automatic logic [7:0] frame_chk(input logic [7:0]  cmd,
                                           input logic [15:0] addr,
                                           input logic [31:0] data);
    return cmd + addr[15:8] + addr[7:0] +
           data[31:24] + data[23:16] + data[15:8] + data[7:0];
  endfunction

endpackage

// File: rtl/cfg_cmd_master_if.sv
// Byte-stream, register-bus and status signals of cfg_cmd_master.
// master: the command master's view; slave: the surrounding system's view.
interface cfg_cmd_master_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic        inter_cfg_wr_en;
  logic        inter_cfg_rd_en;
  logic [15:0] inter_cfg_addr;
  logic [31:0] inter_cfg_wr_data;
  logic [31:0] inter_cfg_rd_data;
  logic        inter_cfg_rd_data_valid;

  logic [15:0] frame_err_cnt;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, inter_cfg_rd_data, inter_cfg_rd_data_valid,
    output rx_ready, tx_data, tx_valid, inter_cfg_wr_en, inter_cfg_rd_en,
           inter_cfg_addr, inter_cfg_wr_data, frame_err_cnt, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, inter_cfg_rd_data, inter_cfg_rd_data_valid,
    input  rx_ready, tx_data, tx_valid, inter_cfg_wr_en, inter_cfg_rd_en,
           inter_cfg_addr, inter_cfg_wr_data, frame_err_cnt, busy
  );

endinterface

// File: rtl/cfg_resp_ser.sv
// Response frame serialiser: latches CMD/ADDR/DATA on i_load, computes the
// checksum and emits the 10-byte frame under the valid/ready handshake.
module cfg_resp_ser
  import cfg_cmd_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [7:0]  i_cmd,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_done
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  logic [7:0]  r_cmd;
  logic [15:0] r_addr;
  logic [31:0] r_data;
  logic [7:0]  r_chk;
  logic [3:0]  r_idx;
  logic        r_valid;
  logic [7:0]  w_byte;

  // Frame registers and byte index; index only advances on a transfer
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_chk   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_cmd   <= i_cmd;
      r_addr  <= i_addr;
      r_data  <= i_data;
      r_chk   <= frame_chk(i_cmd, i_addr, i_data);
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (r_valid && i_tx_ready) begin
      if (r_idx == LAST_IDX) begin
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx   <= r_idx + 4'd1;
      end
    end
  end

  // Byte selection for the current frame position
  always_comb begin
    w_byte = '0;
    case (r_idx)
      4'd0:    w_byte = HDR0;
      4'd1:    w_byte = HDR1;
      4'd2:    w_byte = r_cmd;
      4'd3:    w_byte = r_addr[15:8];
      4'd4:    w_byte = r_addr[7:0];
      4'd5:    w_byte = r_data[31:24];
      4'd6:    w_byte = r_data[23:16];
      4'd7:    w_byte = r_data[15:8];
      4'd8:    w_byte = r_data[7:0];
      4'd9:    w_byte = r_chk;
      default: w_byte = '0;
    endcase
  end

  assign o_tx_data  = r_valid ? w_byte : '0;
  assign o_tx_valid = r_valid;
  assign o_done     = r_valid && i_tx_ready && (r_idx == LAST_IDX);

endmodule

// File: rtl/cfg_cmd_master.sv
// Configuration command master: parses request frames from the receive byte
// stream, issues single-cycle register accesses and returns ack/response
// frames on the transmit byte stream.
module cfg_cmd_master
  import cfg_cmd_pkg::*;
#(
  parameter              U_DLY        = 1,
  parameter logic [15:0] BYTE_TIMEOUT = 16'd50000,
  parameter logic [7:0]  RD_TIMEOUT   = 8'd16
)(
  input  logic              clk_sys,
  input  logic              rst_n,
  cfg_cmd_master_if.master  bus
);

  // U_DLY is kept so existing instantiations still elaborate; registered
  // updates here carry no delay.
  if (U_DLY < 0) begin : g_u_dly_range
  end

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_body_cnt;
  logic [55:0] r_body;        // {CMD, ADDR, DATA} in arrival order
  logic [7:0]  r_chk_rx;
  logic [7:0]  r_sum;
  logic [15:0] r_gap;
  logic [7:0]  r_rd_cnt;

  logic        r_wr_en;
  logic        r_rd_en;
  logic [15:0] r_cfg_addr;
  logic [31:0] r_cfg_wdata;
  logic [15:0] r_err_cnt;

  logic        w_rx_ready;
  logic        w_rx_fire;
  logic        w_gap_expired;
  logic        w_rd_expired;
  logic        w_cmd_known;
  logic        w_frame_ok;
  logic        w_load;
  logic [7:0]  w_resp_cmd;
  logic [31:0] w_resp_data;
  logic        w_ser_done;
  logic [7:0]  w_tx_data;
  logic        w_tx_valid;

  assign w_rx_ready    = (r_state == ST_HUNT0) || (r_state == ST_HUNT1) ||
                         (r_state == ST_BODY);
  assign w_rx_fire     = bus.rx_valid && w_rx_ready;
  assign w_gap_expired = (r_gap == (BYTE_TIMEOUT - 16'd1));
  assign w_rd_expired  = (r_rd_cnt == (RD_TIMEOUT - 8'd1));
  assign w_cmd_known   = (r_body[55:48] == CMD_WR) || (r_body[55:48] == CMD_RD);
  assign w_frame_ok    = (r_sum == r_chk_rx) && w_cmd_known;

  // State register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) r_state <= ST_HUNT0;
    else        r_state <= w_state_nxt;
  end

  // Next state and response-load control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_resp_cmd  = CMD_WR_ACK;
    w_resp_data = r_cfg_wdata;
    case (r_state)
      ST_HUNT0: begin
        if (w_rx_fire && bus.rx_data == HDR0) w_state_nxt = ST_HUNT1;
      end
      ST_HUNT1: begin
        if (w_rx_fire) begin
          if (bus.rx_data == HDR1)      w_state_nxt = ST_BODY;
          else if (bus.rx_data == HDR0) w_state_nxt = ST_HUNT1;
          else                          w_state_nxt = ST_HUNT0;
        end else if (w_gap_expired) begin
          w_state_nxt = ST_HUNT0;
        end
      end
      ST_BODY: begin
        if (w_rx_fire) begin
          if (r_body_cnt == 3'(BODY_LEN - 1)) w_state_nxt = ST_CHECK;
        end else if (w_gap_expired) begin
          w_state_nxt = ST_HUNT0;
        end
      end
      ST_CHECK: begin
        w_state_nxt = w_frame_ok ? ST_ISSUE : ST_HUNT0;
      end
      ST_ISSUE: begin
        if (r_body[55:48] == CMD_WR) begin
          w_state_nxt = ST_RESP;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (bus.inter_cfg_rd_data_valid) begin
          w_state_nxt = ST_RESP;
          w_load      = 1'b1;
          w_resp_cmd  = CMD_RD_RSP;
          w_resp_data = bus.inter_cfg_rd_data;
        end else if (w_rd_expired) begin
          w_state_nxt = ST_RESP;
          w_load      = 1'b1;
          w_resp_cmd  = CMD_RD_TMO;
          w_resp_data = '0;
        end
      end
      ST_RESP: begin
        if (w_ser_done) w_state_nxt = ST_HUNT0;
      end
      default: w_state_nxt = ST_HUNT0;
    endcase
  end

  // Receive-side datapath: inter-byte gap timer, body shift and checksum
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_gap      <= '0;
      r_body_cnt <= '0;
      r_body     <= '0;
      r_chk_rx   <= '0;
      r_sum      <= '0;
    end else begin
      if ((r_state == ST_HUNT1 || r_state == ST_BODY) && !w_rx_fire)
        r_gap <= r_gap + 16'd1;
      else
        r_gap <= '0;

      if (r_state == ST_HUNT1 && w_rx_fire && bus.rx_data == HDR1) begin
        r_body_cnt <= '0;
        r_sum      <= '0;
      end else if (r_state == ST_BODY && w_rx_fire) begin
        r_body_cnt <= r_body_cnt + 3'd1;
        if (r_body_cnt == 3'(BODY_LEN - 1)) begin
          r_chk_rx <= bus.rx_data;
        end else begin
          r_body <= {r_body[47:0], bus.rx_data};
          r_sum  <= r_sum + bus.rx_data;
        end
      end
    end
  end

  // Bus access: strobes registered on leaving CHECK so they cover ISSUE
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_wdata <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      if (r_state == ST_CHECK) begin
        if (w_frame_ok) begin
          r_cfg_addr  <= r_body[47:32];
          r_cfg_wdata <= r_body[31:0];
          r_wr_en     <= (r_body[55:48] == CMD_WR);
          r_rd_en     <= (r_body[55:48] == CMD_RD);
        end else if (r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  // Read wait counter: counts cycles spent in WAIT_RD after the strobe
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                    r_rd_cnt <= '0;
    else if (r_state == ST_WAIT_RD) r_rd_cnt <= r_rd_cnt + 8'd1;
    else                           r_rd_cnt <= '0;
  end

  cfg_resp_ser u_resp_ser (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_cmd      (w_resp_cmd),
    .i_addr     (r_cfg_addr),
    .i_data     (w_resp_data),
    .i_tx_ready (bus.tx_ready),
    .o_tx_data  (w_tx_data),
    .o_tx_valid (w_tx_valid),
    .o_done     (w_ser_done)
  );

  assign bus.rx_ready          = w_rx_ready;
  assign bus.busy              = !w_rx_ready;
  assign bus.tx_data           = w_tx_data;
  assign bus.tx_valid          = w_tx_valid;
  assign bus.inter_cfg_wr_en   = r_wr_en;
  assign bus.inter_cfg_rd_en   = r_rd_en;
  assign bus.inter_cfg_addr    = r_cfg_addr;
  assign bus.inter_cfg_wr_data = r_cfg_wdata;
  assign bus.frame_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_cfg_cmd_master.sv
// Directed testbench for cfg_cmd_master with hand-computed frames.
module tb_cfg_cmd_master;

  localparam logic [79:0] WR1  = 80'hEB90_0100_0112_3456_7816;
  localparam logic [79:0] ACK1 = 80'hEB90_8100_0112_3456_7896;
  localparam logic [79:0] WR1B = 80'hEB90_0100_0112_3456_7817;
  localparam logic [79:0] RD0  = 80'hEB90_0200_0000_0000_0002;
  localparam logic [79:0] RSP0 = 80'hEB90_8200_0000_0000_1092;
  localparam logic [79:0] TMO0 = 80'hEB90_8300_0000_0000_0083;
  localparam logic [79:0] WR2  = 80'hEB90_01A5_C3DE_ADBE_EFA1;
  localparam logic [79:0] ACK2 = 80'hEB90_81A5_C3DE_ADBE_EF21;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   wr_cyc;
  int   rd_cyc;
  int   tx_cyc;

  cfg_cmd_master_if bus ();

  cfg_cmd_master #(
    .U_DLY        (1),
    .BYTE_TIMEOUT (16'd40),
    .RD_TIMEOUT   (8'd16)
  ) u_dut (
    .clk_sys (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.inter_cfg_wr_en === 1'b1) wr_cyc++;
    if (bus.inter_cfg_rd_en === 1'b1) rd_cyc++;
    if (bus.tx_valid === 1'b1)        tx_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input logic [79:0] f, input int lo, input int hi);
    bit ok;
    for (int b = lo; b <= hi; b++) begin
      bus.rx_data  = f[79-8*b -: 8];
      bus.rx_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (bus.rx_ready === 1'b1) begin
          tick();
          ok = 1'b1;
          break;
        end
        tick();
      end
      bus.rx_valid = 1'b0;
      if (!ok) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_accept byte %0d: not accepted within 200 cycles", b);
      end
    end
  endtask

  task automatic wait_tx();
    for (int c = 0; c < 60; c++) begin
      if (bus.tx_valid === 1'b1) break;
      tick();
    end
  endtask

  task automatic recv_frame(output logic [79:0] got, output int nbytes, output int ncyc);
    got = '0;
    nbytes = 0;
    ncyc = 0;
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 200 && nbytes < 10; c++) begin
      if (bus.tx_valid === 1'b1) begin
        got[79-8*nbytes -: 8] = bus.tx_data;
        nbytes++;
      end
      ncyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++; if (bus.rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready got %b exp 1", bus.rx_ready); end
    n_vec++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b exp 0", bus.tx_valid); end
    n_vec++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h exp 00", bus.tx_data); end
    n_vec++; if (bus.inter_cfg_wr_en !== 1'b0 || bus.inter_cfg_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_strobes got wr=%b rd=%b exp 0 0", bus.inter_cfg_wr_en, bus.inter_cfg_rd_en); end
    n_vec++; if (bus.inter_cfg_addr !== 16'h0 || bus.inter_cfg_wr_data !== 32'h0) begin n_err++; $display("FAIL reset_addr_data got %h %h exp 0 0", bus.inter_cfg_addr, bus.inter_cfg_wr_data); end
    n_vec++; if (bus.frame_err_cnt !== 16'h0) begin n_err++; $display("FAIL reset_err_cnt got %h exp 0000", bus.frame_err_cnt); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    logic [79:0] got;
    int nb, nc, wr0;
    wr0 = wr_cyc;
    bus.tx_ready = 1'b1;
    send_range(WR1, 0, 9);
    n_vec++; if (bus.busy !== 1'b1 || bus.rx_ready !== 1'b0) begin n_err++; $display("FAIL wr_check_cycle busy=%b rx_ready=%b exp 1 0", bus.busy, bus.rx_ready); end
    n_vec++; if (bus.inter_cfg_wr_en !== 1'b0) begin n_err++; $display("FAIL wr_early_strobe got %b exp 0", bus.inter_cfg_wr_en); end
    tick();
    n_vec++; if (bus.inter_cfg_wr_en !== 1'b1 || bus.inter_cfg_rd_en !== 1'b0) begin n_err++; $display("FAIL wr_strobe got wr=%b rd=%b exp 1 0", bus.inter_cfg_wr_en, bus.inter_cfg_rd_en); end
    n_vec++; if (bus.inter_cfg_addr !== 16'h0001) begin n_err++; $display("FAIL wr_addr got %h exp 0001", bus.inter_cfg_addr); end
    n_vec++; if (bus.inter_cfg_wr_data !== 32'h12345678) begin n_err++; $display("FAIL wr_data got %h exp 12345678", bus.inter_cfg_wr_data); end
    n_vec++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL wr_tx_early got %b exp 0", bus.tx_valid); end
    tick();
    n_vec++; if (bus.inter_cfg_wr_en !== 1'b0) begin n_err++; $display("FAIL wr_strobe_len got %b exp 0", bus.inter_cfg_wr_en); end
    n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hEB) begin n_err++; $display("FAIL wr_tx_first got v=%b d=%h exp 1 EB", bus.tx_valid, bus.tx_data); end
    recv_frame(got, nb, nc);
    n_vec++; if (got !== ACK1) begin n_err++; $display("FAIL wr_ack_frame got %h exp %h", got, ACK1); end
    n_vec++; if (nc !== 10) begin n_err++; $display("FAIL wr_ack_cycles got %0d exp 10", nc); end
    n_vec++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL wr_done got tx_valid=%b busy=%b exp 0 0", bus.tx_valid, bus.busy); end
    n_vec++; if (wr_cyc - wr0 !== 1) begin n_err++; $display("FAIL wr_strobe_count got %0d exp 1", wr_cyc - wr0); end
    n_vec++; if (bus.inter_cfg_addr !== 16'h0001 || bus.inter_cfg_wr_data !== 32'h12345678) begin n_err++; $display("FAIL wr_addr_hold got %h %h exp 0001 12345678", bus.inter_cfg_addr, bus.inter_cfg_wr_data); end
  endtask

  task automatic test_read();
    logic [79:0] got;
    int nb, nc, rd0, wr0;
    rd0 = rd_cyc;
    wr0 = wr_cyc;
    send_range(RD0, 0, 9);
    tick();
    n_vec++; if (bus.inter_cfg_rd_en !== 1'b1 || bus.inter_cfg_wr_en !== 1'b0) begin n_err++; $display("FAIL rd_strobe got rd=%b wr=%b exp 1 0", bus.inter_cfg_rd_en, bus.inter_cfg_wr_en); end
    n_vec++; if (bus.inter_cfg_addr !== 16'h0000) begin n_err++; $display("FAIL rd_addr got %h exp 0000", bus.inter_cfg_addr); end
    bus.inter_cfg_rd_data       = 32'hFFFF_FFFF;
    bus.inter_cfg_rd_data_valid = 1'b1;
    tick();
    n_vec++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_in_issue got tx_valid=%b exp 0", bus.tx_valid); end
    bus.inter_cfg_rd_data       = 32'h0000_0010;
    bus.inter_cfg_rd_data_valid = 1'b1;
    tick();
    bus.inter_cfg_rd_data_valid = 1'b0;
    bus.inter_cfg_rd_data       = 32'hFFFF_FFFF;
    n_vec++; if (bus.tx_valid !== 1'b1) begin n_err++; $display("FAIL rd_tx_rise got %b exp 1", bus.tx_valid); end
    recv_frame(got, nb, nc);
    n_vec++; if (got !== RSP0) begin n_err++; $display("FAIL rd_resp_frame got %h exp %h", got, RSP0); end
    n_vec++; if (rd_cyc - rd0 !== 1 || wr_cyc - wr0 !== 0) begin n_err++; $display("FAIL rd_strobe_count got rd=%0d wr=%0d exp 1 0", rd_cyc - rd0, wr_cyc - wr0); end
  endtask

  task automatic test_bad_chk();
    logic [79:0] got;
    int nb, nc, wr0, tx0;
    wr0 = wr_cyc;
    tx0 = tx_cyc;
    send_range(WR1B, 0, 9);
    for (int c = 0; c < 20; c++) tick();
    n_vec++; if (wr_cyc - wr0 !== 0) begin n_err++; $display("FAIL badchk_strobe got %0d exp 0", wr_cyc - wr0); end
    n_vec++; if (tx_cyc - tx0 !== 0) begin n_err++; $display("FAIL badchk_tx got %0d valid cycles exp 0", tx_cyc - tx0); end
    n_vec++; if (bus.frame_err_cnt !== 16'd1) begin n_err++; $display("FAIL badchk_err_cnt got %0d exp 1", bus.frame_err_cnt); end
    send_range(WR1, 0, 9);
    wait_tx();
    recv_frame(got, nb, nc);
    n_vec++; if (got !== ACK1) begin n_err++; $display("FAIL badchk_recover_frame got %h exp %h", got, ACK1); end
    n_vec++; if (wr_cyc - wr0 !== 1) begin n_err++; $display("FAIL badchk_recover_strobe got %0d exp 1", wr_cyc - wr0); end
  endtask

  task automatic test_rd_timeout();
    logic [79:0] got;
    int nb, nc, k;
    bus.inter_cfg_rd_data_valid = 1'b0;
    send_range(RD0, 0, 9);
    tick();
    n_vec++; if (bus.inter_cfg_rd_en !== 1'b1) begin n_err++; $display("FAIL tmo_strobe got %b exp 1", bus.inter_cfg_rd_en); end
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      k = c;
      if (bus.tx_valid === 1'b1) break;
    end
    n_vec++; if (k !== 17) begin n_err++; $display("FAIL tmo_latency got tx_valid %0d cycles after strobe cycle exp 17", k); end
    recv_frame(got, nb, nc);
    n_vec++; if (got !== TMO0) begin n_err++; $display("FAIL tmo_frame got %h exp %h", got, TMO0); end
  endtask

  task automatic test_resync();
    logic [79:0] got;
    logic [79:0] one_eb;
    int nb, nc, wr0;
    one_eb = 80'hEB00_0000_0000_0000_0000;
    wr0 = wr_cyc;
    send_range(one_eb, 0, 0);
    send_range(WR2, 0, 9);
    wait_tx();
    recv_frame(got, nb, nc);
    n_vec++; if (got !== ACK2) begin n_err++; $display("FAIL resync_eb_eb_frame got %h exp %h", got, ACK2); end
    n_vec++; if (bus.inter_cfg_addr !== 16'hA5C3 || bus.inter_cfg_wr_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL resync_addr_data got %h %h exp A5C3 DEADBEEF", bus.inter_cfg_addr, bus.inter_cfg_wr_data); end
    send_range(WR1, 0, 4);
    for (int c = 0; c < 30; c++) tick();
    send_range(WR1, 5, 9);
    wait_tx();
    recv_frame(got, nb, nc);
    n_vec++; if (got !== ACK1) begin n_err++; $display("FAIL short_gap_frame got %h exp %h", got, ACK1); end
    wr0 = wr_cyc;
    send_range(WR2, 0, 3);
    for (int c = 0; c < 45; c++) tick();
    n_vec++; if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL byte_tmo_idle got rx_ready=%b busy=%b exp 1 0", bus.rx_ready, bus.busy); end
    send_range(WR1, 0, 9);
    wait_tx();
    recv_frame(got, nb, nc);
    n_vec++; if (got !== ACK1) begin n_err++; $display("FAIL byte_tmo_frame got %h exp %h", got, ACK1); end
    n_vec++; if (wr_cyc - wr0 !== 1) begin n_err++; $display("FAIL byte_tmo_strobes got %0d exp 1", wr_cyc - wr0); end
    n_vec++; if (bus.frame_err_cnt !== 16'd1) begin n_err++; $display("FAIL byte_tmo_err_cnt got %0d exp 1", bus.frame_err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [79:0] got;
    logic [7:0]  held;
    bit          stalled;
    int          nb;
    bus.tx_ready = 1'b0;
    send_range(WR2, 0, 9);
    wait_tx();
    got = '0;
    nb = 0;
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < 100 && nb < 10; c++) begin
      bus.tx_ready = (c % 2 == 1);
      if (bus.tx_valid === 1'b1) begin
        if (stalled) begin
          n_vec++; if (bus.tx_data !== held) begin n_err++; $display("FAIL bp_stable byte %0d got %h exp %h", nb, bus.tx_data, held); end
        end
        if (bus.tx_ready) begin
          got[79-8*nb -: 8] = bus.tx_data;
          nb++;
          stalled = 1'b0;
        end else begin
          held = bus.tx_data;
          stalled = 1'b1;
        end
      end
      tick();
    end
    bus.tx_ready = 1'b1;
    n_vec++; if (nb !== 10 || got !== ACK2) begin n_err++; $display("FAIL bp_frame got %0d bytes %h exp 10 %h", nb, got, ACK2); end
  endtask

  task automatic test_reset_mid_resp();
    logic [79:0] got;
    int nb, nc, tx0;
    bus.tx_ready = 1'b1;
    send_range(WR1, 0, 9);
    wait_tx();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_tx got v=%b d=%h exp 0 00", bus.tx_valid, bus.tx_data); end
    n_vec++; if (bus.busy !== 1'b0 || bus.rx_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_state got busy=%b rx_ready=%b exp 0 1", bus.busy, bus.rx_ready); end
    n_vec++; if (bus.frame_err_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_err_cnt got %0d exp 0", bus.frame_err_cnt); end
    tick();
    rst_n = 1'b1;
    tx0 = tx_cyc;
    for (int c = 0; c < 5; c++) tick();
    n_vec++; if (tx_cyc - tx0 !== 0) begin n_err++; $display("FAIL rst_no_resume got %0d tx cycles exp 0", tx_cyc - tx0); end
    send_range(WR2, 0, 9);
    wait_tx();
    recv_frame(got, nb, nc);
    n_vec++; if (got !== ACK2) begin n_err++; $display("FAIL rst_recover_frame got %h exp %h", got, ACK2); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wr_cyc = 0;
    rd_cyc = 0;
    tx_cyc = 0;
    rst_n = 1'b0;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    bus.inter_cfg_rd_data = '0;
    bus.inter_cfg_rd_data_valid = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_bad_chk();
    test_rd_timeout();
    test_resync();
    test_backpressure();
    test_reset_mid_resp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
